// File: rtl/tt_trng_pkg.sv
// Shared types and defaults for the inverter-ring TRNG controller.
package tt_trng_pkg;

  // Controller FSM states; also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } trng_state_t;

  localparam int DEF_WORD_W        = 8;
  localparam int DEF_WARMUP_CYCLES = 64;
  localparam int DEF_SAMPLE_DIV    = 4;
  localparam int DEF_REP_LIMIT     = 16;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_trng_if.sv
// Random-word delivery channel between the controller and its consumer.
//
// Handshake: the master raises rnd_valid with rnd_data and keeps both stable
// until a rising clk edge sees rnd_valid && rnd_ready; that edge is the
// transfer. rnd_ready may be driven freely and may depend on rnd_valid; the
// master never waits for rnd_ready before raising rnd_valid.
interface tt_trng_if
  import tt_trng_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);

  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              rnd_ready;

  modport master (
    output rnd_data,
    output rnd_valid,
    input  rnd_ready
  );

  modport slave (
    input  rnd_data,
    input  rnd_valid,
    output rnd_ready
  );

endinterface

// File: rtl/tt_trng_reptest.sv
// Repetition-count health test on the decimated raw bit stream.
// fail is a look-ahead: it is high on the sample that brings the run of
// identical bits up to REP_LIMIT, so the controller can react on that edge.
module tt_trng_reptest
  import tt_trng_pkg::*;
#(
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic sample_en,
  input  logic bit_in,
  output logic fail
);

  localparam int RUN_W = $clog2(REP_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(REP_LIMIT);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(REP_LIMIT - 1);

  logic             last_bit;
  logic [RUN_W-1:0] run_cnt;
  logic             repeat_hit;

  // A zero run means no sample has been seen since the last clear.
  assign repeat_hit = (run_cnt != '0) && (bit_in == last_bit);
  assign fail       = sample_en && repeat_hit && (run_cnt >= RUN_PRE);

  // Track the last sample and a saturating count of identical samples.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      last_bit <= 1'b0;
      run_cnt  <= '0;
    end else if (sample_en) begin
      last_bit <= bit_in;
      if (!repeat_hit) begin
        run_cnt <= RUN_W'(1);
      end else if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/tt_trng_ctrl.sv
// Sequencing controller for the inverter-ring entropy source: gates the
// rings, waits out warm-up, decimates and packs raw bits into words, runs the
// repetition health test and hands words out over a valid/ready channel.
module tt_trng_ctrl
  import tt_trng_pkg::*;
#(
  parameter int WORD_W        = DEF_WORD_W,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             raw_bit,
  output logic             ring_start,
  output logic             fault,
  input  logic             clear_fault,
  tt_trng_if.master        rnd,
  output trng_state_t      dbg_state
);

  localparam int WU_W  = cnt_w(WARMUP_CYCLES);
  localparam int DIV_W = cnt_w(SAMPLE_DIV);
  localparam int BIT_W = cnt_w(WORD_W);

  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  trng_state_t       state, state_next;
  logic [WU_W-1:0]   wu_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] shreg_next;
  logic [WORD_W-1:0] data_q;
  logic              valid_q;
  logic              ring_q;
  logic              fault_q;
  logic              sample_en;
  logic              word_done;
  logic              fresh;
  logic              rep_fail;

  // Bits collected so far plus the incoming one; MSB is the oldest sample.
  assign shreg_next = {shreg, raw_bit};

  // Entering COLLECT from anywhere starts a brand-new word.
  assign fresh = (state_next == ST_COLLECT) && (state != ST_COLLECT);

  tt_trng_reptest #(
    .REP_LIMIT (REP_LIMIT)
  ) u_reptest (
    .clk       (clk),
    .rst       (rst),
    .clr       (fresh),
    .sample_en (sample_en),
    .bit_in    (raw_bit),
    .fail      (rep_fail)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle strobes; dropping enable aborts before sampling,
  // and a health failure outranks completing the word.
  always_comb begin
    state_next = state;
    sample_en  = 1'b0;
    word_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!enable)               state_next = ST_IDLE;
        else if (wu_cnt == WU_LAST) state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (div_cnt == DIV_LAST) begin
          sample_en = 1'b1;
          if (rep_fail) begin
            state_next = ST_FAULT;
          end else if (bit_cnt == BIT_LAST) begin
            word_done  = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!enable)            state_next = ST_IDLE;
        else if (rnd.rnd_ready) state_next = ST_COLLECT;
      end
      ST_FAULT: begin
        if (clear_fault) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wu_cnt  <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ring_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      ring_q  <= state_next inside {ST_WARMUP, ST_COLLECT, ST_HOLD};
      valid_q <= (state_next == ST_HOLD);
      fault_q <= (state_next == ST_FAULT);

      if (state == ST_IDLE)        wu_cnt <= '0;
      else if (state == ST_WARMUP) wu_cnt <= wu_cnt + WU_W'(1);

      if (fresh) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (state == ST_COLLECT) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        if (sample_en) begin
          shreg   <= shreg_next[WORD_W-2:0];
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end

      if (word_done) data_q <= shreg_next;
    end
  end

  assign ring_start    = ring_q;
  assign fault         = fault_q;
  assign rnd.rnd_data  = data_q;
  assign rnd.rnd_valid = valid_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_tt_trng_ctrl.sv
// Directed self-checking bench for tt_trng_ctrl: one instance with
// SAMPLE_DIV=1 for packing/handshake/fault/abort, one with SAMPLE_DIV=4 for
// decimation. Inputs change on the falling edge, outputs are read there too.
module tb_tt_trng_ctrl;
  import tt_trng_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT 1: SAMPLE_DIV = 1 ----------------
  logic        enable, raw_bit, clear_fault, ring_start, fault;
  trng_state_t dbg_state;
  tt_trng_if #(.WORD_W(8)) rnd_if ();

  tt_trng_ctrl #(
    .WORD_W(8), .WARMUP_CYCLES(4), .SAMPLE_DIV(1), .REP_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .raw_bit(raw_bit),
    .ring_start(ring_start), .fault(fault), .clear_fault(clear_fault),
    .rnd(rnd_if), .dbg_state(dbg_state)
  );

  // ---------------- DUT 2: SAMPLE_DIV = 4 ----------------
  logic        enable2, raw_bit2, clear_fault2, ring_start2, fault2;
  trng_state_t dbg_state2;
  tt_trng_if #(.WORD_W(8)) rnd_if2 ();

  tt_trng_ctrl #(
    .WORD_W(8), .WARMUP_CYCLES(4), .SAMPLE_DIV(4), .REP_LIMIT(4)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(enable2), .raw_bit(raw_bit2),
    .ring_start(ring_start2), .fault(fault2), .clear_fault(clear_fault2),
    .rnd(rnd_if2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every accepted word on DUT 1 must be the next expected one.
  always @(negedge clk) begin
    #1;
    if (!rst && rnd_if.rnd_valid && rnd_if.rnd_ready) begin
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      else                   exp_w = 8'hxx;
      check_eq("sb_word", rnd_if.rnd_data, exp_w);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Feed one word MSB first, one sample per cycle, starting right after
  // COLLECT entry or a handshake; rnd_valid must not rise before the last bit.
  task automatic drive_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      raw_bit = w[i];
      if (i == 0) begin
        check_eq("valid_not_early", rnd_if.rnd_valid, 1'b0);
        check_eq("fault_not_early", fault, 1'b0);
      end
      tick(1);
    end
  endtask

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic       drv[32];
  logic [7:0] dec;
  logic [7:0] model_w;

  initial begin
    rst = 1'b1; enable = 1'b1; raw_bit = 1'b0; clear_fault = 1'b0;
    rnd_if.rnd_ready = 1'b0;
    enable2 = 1'b0; raw_bit2 = 1'b0; clear_fault2 = 1'b0;
    rnd_if2.rnd_ready = 1'b0;

    // Reset held two cycles with enable high.
    tick(2);
    check_eq("rst_ring_start", ring_start, 1'b0);
    check_eq("rst_valid", rnd_if.rnd_valid, 1'b0);
    check_eq("rst_data", rnd_if.rnd_data, 8'h00);
    check_eq("rst_fault", fault, 1'b0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick(1);
    check_eq("release_ring_start", ring_start, 1'b1);
    check_eq("release_state", dbg_state, ST_WARMUP);
    tick(3);
    check_eq("warmup_still", dbg_state, ST_WARMUP);
    tick(1);
    check_eq("collect_entry", dbg_state, ST_COLLECT);

    // Word packing: 1,0,1,1,0,0,1,0 -> 0xB2.
    drive_word(8'hB2);
    check_eq("pack_valid", rnd_if.rnd_valid, 1'b1);
    check_eq("pack_data", rnd_if.rnd_data, 8'hB2);

    // Backpressure: 20 cycles with rnd_ready low and noisy raw bits.
    for (int i = 0; i < 20; i++) begin
      raw_bit = 1'($urandom_range(0, 1));
      tick(1);
      check_eq("bp_valid", rnd_if.rnd_valid, 1'b1);
      check_eq("bp_data", rnd_if.rnd_data, 8'hB2);
    end
    check_eq("bp_state", dbg_state, ST_HOLD);
    exp_q.push_back(8'hB2);
    rnd_if.rnd_ready = 1'b1;
    tick(1);
    rnd_if.rnd_ready = 1'b0;
    check_eq("hs_valid_fall", rnd_if.rnd_valid, 1'b0);
    check_eq("hs_state", dbg_state, ST_COLLECT);
    drive_word(8'h69);
    check_eq("word2_valid", rnd_if.rnd_valid, 1'b1);
    check_eq("word2_data", rnd_if.rnd_data, 8'h69);

    // Throughput with rnd_ready held high: 9 cycles per word.
    exp_q.push_back(8'h69);
    exp_q.push_back(8'hA5);
    rnd_if.rnd_ready = 1'b1;
    tick(1);
    check_eq("hs2_valid_fall", rnd_if.rnd_valid, 1'b0);
    drive_word(8'hA5);
    check_eq("tp_valid", rnd_if.rnd_valid, 1'b1);
    check_eq("tp_data", rnd_if.rnd_data, 8'hA5);
    tick(1);
    rnd_if.rnd_ready = 1'b0;
    check_eq("tp_valid_fall", rnd_if.rnd_valid, 1'b0);

    // Abort mid-COLLECT.
    raw_bit = 1'b1; tick(1);
    raw_bit = 1'b0; tick(1);
    raw_bit = 1'b1; tick(1);
    enable = 1'b0;
    tick(1);
    check_eq("abort_c_state", dbg_state, ST_IDLE);
    check_eq("abort_c_ring", ring_start, 1'b0);
    check_eq("abort_c_valid", rnd_if.rnd_valid, 1'b0);
    check_eq("abort_c_data_hold", rnd_if.rnd_data, 8'hA5);

    // Re-enable: full warm-up; a stray clear_fault is ignored.
    enable = 1'b1;
    tick(1);
    check_eq("reen_ring", ring_start, 1'b1);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    tick(2);
    check_eq("reen_warmup", dbg_state, ST_WARMUP);
    tick(1);
    check_eq("reen_collect", dbg_state, ST_COLLECT);
    drive_word(8'hAA);
    check_eq("hold_data", rnd_if.rnd_data, 8'hAA);

    // Abort mid-HOLD with a handshake on the same edge.
    exp_q.push_back(8'hAA);
    enable = 1'b0;
    rnd_if.rnd_ready = 1'b1;
    tick(1);
    rnd_if.rnd_ready = 1'b0;
    check_eq("abort_h_state", dbg_state, ST_IDLE);
    check_eq("abort_h_valid", rnd_if.rnd_valid, 1'b0);

    // Health fault: raw_bit stuck at 1.
    raw_bit = 1'b1;
    enable = 1'b1;
    tick(5);
    check_eq("hf_collect", dbg_state, ST_COLLECT);
    tick(3);
    check_eq("hf_fault_pre", fault, 1'b0);
    check_eq("hf_ring_pre", ring_start, 1'b1);
    tick(1);
    check_eq("hf_fault", fault, 1'b1);
    check_eq("hf_ring_off", ring_start, 1'b0);
    check_eq("hf_valid", rnd_if.rnd_valid, 1'b0);
    check_eq("hf_state", dbg_state, ST_FAULT);
    enable = 1'b0;
    tick(1);
    check_eq("hf_en_low_state", dbg_state, ST_FAULT);
    enable = 1'b1;
    tick(1);
    check_eq("hf_en_high_fault", fault, 1'b1);
    check_eq("hf_en_high_ring", ring_start, 1'b0);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    check_eq("clr_state", dbg_state, ST_IDLE);
    check_eq("clr_fault", fault, 1'b0);
    tick(1);
    check_eq("clr_then_warmup", dbg_state, ST_WARMUP);
    check_eq("clr_then_ring", ring_start, 1'b1);

    // Word completion and run limit on the same sample: FAULT wins.
    tick(4);
    check_eq("fw_collect", dbg_state, ST_COLLECT);
    drive_word(8'hAF);
    check_eq("fw_state", dbg_state, ST_FAULT);
    check_eq("fw_valid", rnd_if.rnd_valid, 1'b0);
    check_eq("fw_fault", fault, 1'b1);
    check_eq("fw_data_hold", rnd_if.rnd_data, 8'hAA);
    enable = 1'b0;
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    check_eq("fw_clr_state", dbg_state, ST_IDLE);

    // Decimation on DUT 2: only every 4th cycle's bit counts.
    dec = 8'hC5;
    for (int i = 0; i < 32; i++) begin
      drv[i] = ((i % 4) == 3) ? dec[7 - (i / 4)] : ~dec[7 - (i / 4)];
    end
    model_w = '0;
    for (int k = 0; k < 8; k++) model_w = {model_w[6:0], drv[4 * k + 3]};
    enable2 = 1'b1;
    tick(1);
    check_eq("d_ring", ring_start2, 1'b1);
    tick(3);
    check_eq("d_warmup", dbg_state2, ST_WARMUP);
    tick(1);
    check_eq("d_collect", dbg_state2, ST_COLLECT);
    for (int i = 0; i < 32; i++) begin
      raw_bit2 = drv[i];
      if (i == 31) check_eq("d_valid_early", rnd_if2.rnd_valid, 1'b0);
      tick(1);
    end
    check_eq("d_valid", rnd_if2.rnd_valid, 1'b1);
    check_eq("d_data_model", rnd_if2.rnd_data, model_w);
    check_eq("d_data_hand", rnd_if2.rnd_data, 8'hC5);
    rnd_if2.rnd_ready = 1'b1;
    tick(1);
    rnd_if2.rnd_ready = 1'b0;
    check_eq("d_hs_valid", rnd_if2.rnd_valid, 1'b0);
    check_eq("d_hs_state", dbg_state2, ST_COLLECT);

    // Toggling every cycle decimates to a constant stream -> fault on 4th sample.
    for (int i = 0; i < 16; i++) begin
      raw_bit2 = i[0];
      if (i == 15) check_eq("d_fault_pre", fault2, 1'b0);
      tick(1);
    end
    check_eq("d_fault", fault2, 1'b1);
    check_eq("d_fault_ring", ring_start2, 1'b0);
    check_eq("d_fault_valid", rnd_if2.rnd_valid, 1'b0);
    check_eq("d_fault_state", dbg_state2, ST_FAULT);

    // Reset mid-operation clears the sticky fault.
    rst = 1'b1;
    tick(1);
    check_eq("mrst_fault", fault2, 1'b0);
    check_eq("mrst_state", dbg_state2, ST_IDLE);
    check_eq("mrst_data", rnd_if2.rnd_data, 8'h00);
    rst = 1'b0;
    tick(2);

    // ---------------- final report ----------------
    check_eq("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
